// File: rtl/mxint_cast_stream.sv
// Streaming MxInt re-caster: buffers a block of NUM_BEATS beats in one of two banks,
// then re-emits it with a new shared exponent and re-quantised mantissas.
module mxint_cast_stream #(
    parameter int IN_MAN_WIDTH  = 8,
    parameter int IN_EXP_WIDTH  = 4,
    parameter int OUT_MAN_WIDTH = 4,
    parameter int OUT_EXP_WIDTH = 4,
    parameter int PARALLELISM   = 2,
    parameter int NUM_BEATS     = 2,
    parameter int ROUND_MODE    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [IN_MAN_WIDTH-1:0]  mdata_in [PARALLELISM],
    input  logic        [IN_EXP_WIDTH-1:0]  edata_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic signed [OUT_MAN_WIDTH-1:0] mdata_out [PARALLELISM],
    output logic        [OUT_EXP_WIDTH-1:0] edata_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic                            last_out,
    output logic                            sat_out
);
    localparam int EBIAS_IN  = 2**(IN_EXP_WIDTH-1) - 1;
    localparam int EBIAS_OUT = 2**(OUT_EXP_WIDTH-1) - 1;
    localparam int LW   = $clog2(IN_MAN_WIDTH + 1);
    localparam int EW0  = (IN_EXP_WIDTH > OUT_EXP_WIDTH) ? IN_EXP_WIDTH : OUT_EXP_WIDTH;
    localparam int EW1  = $clog2(IN_MAN_WIDTH) + 1;
    localparam int EW   = ((EW0 > EW1) ? EW0 : EW1) + 2;
    localparam int SW   = EW + 2;
    localparam int WW   = IN_MAN_WIDTH + OUT_MAN_WIDTH + 1;
    localparam int AMAX = (OUT_MAN_WIDTH > IN_MAN_WIDTH + 1) ? OUT_MAN_WIDTH : IN_MAN_WIDTH + 1;
    localparam int AW   = $clog2(AMAX + 1);
    localparam int BW   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    localparam logic signed [EW-1:0] K_E    = EW'(EBIAS_OUT - EBIAS_IN - IN_MAN_WIDTH + 1);
    localparam logic signed [EW-1:0] EMAX_E = EW'(2**OUT_EXP_WIDTH - 1);
    localparam logic signed [SW-1:0] K_S    = SW'(OUT_MAN_WIDTH - 1);
    localparam logic signed [SW-1:0] LMAX_S = SW'(OUT_MAN_WIDTH);
    localparam logic signed [SW-1:0] RMAX_S = SW'(IN_MAN_WIDTH + 1);
    localparam logic signed [WW-1:0] OMAX_W = WW'(2**(OUT_MAN_WIDTH-1) - 1);
    localparam logic signed [WW-1:0] OMIN_W = -OMAX_W;
    localparam logic signed [OUT_MAN_WIDTH-1:0] OMAX_Q = OUT_MAN_WIDTH'(2**(OUT_MAN_WIDTH-1) - 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_STREAM} state_t;

    state_t                           r_state, w_next;
    logic                             r_rst_done;
    logic [1:0]                       r_full;
    logic                             r_wr_bank, r_rd_bank;
    logic [BW-1:0]                    r_wr_beat, r_rd_beat;
    logic [IN_MAN_WIDTH-1:0]          r_max;
    logic [IN_EXP_WIDTH-1:0]          r_exp [2];
    logic [LW-1:0]                    r_len [2];
    logic signed [IN_MAN_WIDTH-1:0]   r_man [2][NUM_BEATS][PARALLELISM];
    logic [OUT_EXP_WIDTH-1:0]         r_eout;
    logic                             r_left;
    logic [AW-1:0]                    r_amt;

    logic [IN_MAN_WIDTH-1:0]          w_abs, w_beat_max;
    logic                             w_wr_fire, w_wr_last, w_rd_fire, w_rd_last, w_stream;
    logic signed [EW-1:0]             w_efull;
    logic [OUT_EXP_WIDTH-1:0]         w_eout;
    logic signed [SW-1:0]             w_efull_x, w_eout_x, w_len_x, w_shift, w_neg;
    logic                             w_left;
    logic [AW-1:0]                    w_amt;
    logic signed [OUT_MAN_WIDTH-1:0]  w_conv [PARALLELISM];
    logic [PARALLELISM-1:0]           w_sat;

    function automatic logic [LW-1:0] bit_len(input logic [IN_MAN_WIDTH-1:0] v);
        bit_len = '0;
        for (int i = 0; i < IN_MAN_WIDTH; i++)
            if (v[i]) bit_len = LW'(i + 1);
    endfunction

    // Ready depends on registers only, so it cannot loop back through data_in_valid.
    assign data_in_ready = r_rst_done && !r_full[r_wr_bank];
    assign w_wr_fire     = data_in_valid && data_in_ready;
    assign w_wr_last     = w_wr_fire && (r_wr_beat == BW'(NUM_BEATS - 1));
    assign w_stream      = (r_state == S_STREAM);
    assign w_rd_fire     = w_stream && data_out_ready;
    assign w_rd_last     = w_rd_fire && (r_rd_beat == BW'(NUM_BEATS - 1));

    always_comb begin
        w_abs      = '0;
        w_beat_max = r_max;
        for (int p = 0; p < PARALLELISM; p++) begin
            w_abs = mdata_in[p][IN_MAN_WIDTH-1] ? (~mdata_in[p] + IN_MAN_WIDTH'(1)) : mdata_in[p];
            if (w_abs > w_beat_max) w_beat_max = w_abs;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire)
            for (int p = 0; p < PARALLELISM; p++)
                r_man[r_wr_bank][r_wr_beat][p] <= mdata_in[p];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rst_done <= 1'b0;
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_beat  <= '0;
            r_rd_beat  <= '0;
            r_max      <= '0;
            r_exp      <= '{default: '0};
            r_len      <= '{default: '0};
            r_eout     <= '0;
            r_left     <= 1'b0;
            r_amt      <= '0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_wr_fire) begin
                if (r_wr_beat == '0) r_exp[r_wr_bank] <= edata_in;
                if (w_wr_last) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_len[r_wr_bank]  <= bit_len(w_beat_max);
                    r_wr_bank         <= ~r_wr_bank;
                    r_max             <= '0;
                    r_wr_beat         <= '0;
                end else begin
                    r_max     <= w_beat_max;
                    r_wr_beat <= r_wr_beat + BW'(1);
                end
            end
            if (w_rd_fire) begin
                if (w_rd_last) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= ~r_rd_bank;
                    r_rd_beat         <= '0;
                end else begin
                    r_rd_beat <= r_rd_beat + BW'(1);
                end
            end
            if (r_state == S_PREP) begin
                r_eout <= w_eout;
                r_left <= w_left;
                r_amt  <= w_amt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // When the other bank is already full the read side skips IDLE so back-to-back
    // blocks cost only the one PREP bubble.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (r_full[r_rd_bank]) w_next = S_PREP;
            S_PREP:   w_next = S_STREAM;
            S_STREAM: if (w_rd_last) w_next = r_full[~r_rd_bank] ? S_PREP : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_efull   = $signed({{(EW-IN_EXP_WIDTH){1'b0}}, r_exp[r_rd_bank]})
                  + $signed({{(EW-LW){1'b0}}, r_len[r_rd_bank]}) + K_E;
        w_eout    = '0;
        if (r_len[r_rd_bank] == '0 || w_efull < 0) w_eout = '0;
        else if (w_efull > EMAX_E)                 w_eout = EMAX_E[OUT_EXP_WIDTH-1:0];
        else                                       w_eout = w_efull[OUT_EXP_WIDTH-1:0];
        w_efull_x = {{(SW-EW){w_efull[EW-1]}}, w_efull};
        w_eout_x  = {{(SW-OUT_EXP_WIDTH){1'b0}}, w_eout};
        w_len_x   = {{(SW-LW){1'b0}}, r_len[r_rd_bank]};
        w_shift   = w_efull_x - w_eout_x + K_S - w_len_x;
        w_neg     = -w_shift;
        w_left    = !w_shift[SW-1];
        // Shift amounts are clamped where the result no longer changes (full saturation / 0 or -1).
        if (w_left) w_amt = (w_shift > LMAX_S) ? AW'(OUT_MAN_WIDTH) : w_shift[AW-1:0];
        else        w_amt = (w_neg > RMAX_S) ? AW'(IN_MAN_WIDTH + 1) : w_neg[AW-1:0];
    end

    for (genvar gp = 0; gp < PARALLELISM; gp++) begin : g_elem
        logic signed [IN_MAN_WIDTH-1:0]  w_m;
        logic signed [WW-1:0]            w_mx, w_res;
        logic [WW-1:0]                   w_mag, w_rnd;
        logic signed [OUT_MAN_WIDTH-1:0] w_q;
        logic                            w_s;

        assign w_m   = r_man[r_rd_bank][r_rd_beat][gp];
        assign w_mx  = {{(WW-IN_MAN_WIDTH){w_m[IN_MAN_WIDTH-1]}}, w_m};
        assign w_mag = w_m[IN_MAN_WIDTH-1] ? -w_mx : w_mx;
        assign w_rnd = (w_mag + (WW'(1) << (r_amt - AW'(1)))) >> r_amt;

        always_comb begin
            w_res = '0;
            if (w_m == '0)           w_res = '0;
            else if (r_left)         w_res = w_mx <<< r_amt;
            else if (ROUND_MODE == 0) w_res = w_mx >>> r_amt;
            else                     w_res = w_m[IN_MAN_WIDTH-1] ? -$signed(w_rnd) : $signed(w_rnd);
            w_s = 1'b0;
            w_q = w_res[OUT_MAN_WIDTH-1:0];
            if (w_res > OMAX_W) begin
                w_q = OMAX_Q;
                w_s = 1'b1;
            end else if (w_res < OMIN_W) begin
                w_q = -OMAX_Q;
                w_s = 1'b1;
            end
        end

        assign w_conv[gp] = w_q;
        assign w_sat[gp]  = w_s;
    end

    always_comb begin
        for (int p = 0; p < PARALLELISM; p++)
            mdata_out[p] = w_stream ? w_conv[p] : '0;
    end

    assign data_out_valid = w_stream;
    assign edata_out      = w_stream ? r_eout : '0;
    assign last_out       = w_stream && (r_rd_beat == BW'(NUM_BEATS - 1));
    assign sat_out        = w_stream && (|w_sat);

endmodule
